// File: rtl/i2s_pkg.sv
// Shared types and default widths for the I2S TX frame sequencer.
package i2s_pkg;

  localparam int I2S_NUM_BITS_W  = 5;
  localparam int I2S_NUM_WORD_W  = 4;
  localparam int I2S_GAP_W       = 8;
  localparam int I2S_FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FRAME = 2'd2,
    GAP   = 2'd3
  } i2s_frame_state_e;

endpackage

// File: rtl/i2s_slot_counter.sv
// Nested bit/word counter for one I2S frame. Limits are latched on load so a
// config change mid-frame only matters at the next load. The wrap flags are
// registered together with the indices, so they are valid in the same cycle
// as the index they describe.
module i2s_slot_counter
  import i2s_pkg::*;
#(
  parameter int NUM_BITS_W = I2S_NUM_BITS_W,
  parameter int NUM_WORD_W = I2S_NUM_WORD_W
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [NUM_BITS_W-1:0] num_bits_i,
  input  logic [NUM_WORD_W-1:0] num_word_i,
  output logic [NUM_BITS_W-1:0] bit_idx_o,
  output logic [NUM_WORD_W-1:0] word_idx_o,
  output logic                  bit_last_o,
  output logic                  frame_last_o
);

  logic [NUM_BITS_W-1:0] r_bit;
  logic [NUM_WORD_W-1:0] r_word;
  logic [NUM_BITS_W-1:0] r_lim_bits;
  logic [NUM_WORD_W-1:0] r_lim_word;
  logic                  r_bit_last;
  logic                  r_frame_last;
  logic [NUM_BITS_W-1:0] w_nxt_bit;
  logic [NUM_WORD_W-1:0] w_nxt_word;

  // Next position: bit wraps against the latched limit and carries into word.
  always_comb begin
    w_nxt_bit  = r_bit + 1'b1;
    w_nxt_word = r_word;
    if (r_bit_last) begin
      w_nxt_bit  = '0;
      w_nxt_word = r_frame_last ? '0 : (r_word + 1'b1);
    end
  end

  // Index, limit and wrap-flag registers; clear has priority over load.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bit        <= '0;
      r_word       <= '0;
      r_lim_bits   <= '0;
      r_lim_word   <= '0;
      r_bit_last   <= 1'b0;
      r_frame_last <= 1'b0;
    end else if (clear_i) begin
      r_bit        <= '0;
      r_word       <= '0;
      r_bit_last   <= 1'b0;
      r_frame_last <= 1'b0;
    end else if (load_i) begin
      r_bit        <= '0;
      r_word       <= '0;
      r_lim_bits   <= num_bits_i;
      r_lim_word   <= num_word_i;
      r_bit_last   <= (num_bits_i == '0);
      r_frame_last <= (num_bits_i == '0) && (num_word_i == '0);
    end else if (adv_i) begin
      r_bit        <= w_nxt_bit;
      r_word       <= w_nxt_word;
      r_bit_last   <= (w_nxt_bit == r_lim_bits);
      r_frame_last <= (w_nxt_bit == r_lim_bits) && (w_nxt_word == r_lim_word);
    end
  end

  assign bit_idx_o    = r_bit;
  assign word_idx_o   = r_word;
  assign bit_last_o   = r_bit_last;
  assign frame_last_o = r_frame_last;

endmodule

// File: rtl/i2s_tx_frame_ctrl.sv
// Master-side I2S/DSP TX frame sequencer (sck domain).
// Optional frame statistics counter: define I2S_TX_FRAME_CTRL_STATS_EN.
// Handshake: the sequencer leaves IDLE (and starts each new frame after a gap)
// only when cfg_en_i and ready_to_send_i are both high on a rising sck edge;
// there is no back-pressure once a frame has started, and cfg_en_i low aborts
// immediately. dbg_state_o exposes the FSM state for checkers.
module i2s_tx_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int NUM_BITS_W = I2S_NUM_BITS_W,
  parameter int NUM_WORD_W = I2S_NUM_WORD_W,
  parameter int GAP_W      = I2S_GAP_W
) (
  input  logic                       sck_i,
  input  logic                       rstn_i,
  input  logic                       cfg_en_i,
  input  logic                       cfg_dsp_mode_i,
  input  logic [NUM_BITS_W-1:0]      cfg_num_bits_i,
  input  logic [NUM_WORD_W-1:0]      cfg_num_word_i,
  input  logic [GAP_W-1:0]           cfg_gap_i,
  input  logic                       ready_to_send_i,
  input  logic                       fifo_valid_i,
  output logic                       ws_o,
  output logic                       frame_start_o,
  output logic                       frame_done_o,
  output logic [NUM_WORD_W-1:0]      word_idx_o,
  output logic [NUM_BITS_W-1:0]      bit_idx_o,
  output logic                       busy_o,
  output logic                       underrun_o,
  output logic [I2S_FRAME_CNT_W-1:0] frame_cnt_o,
  output i2s_frame_state_e           dbg_state_o
);

  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  i2s_frame_state_e r_state;
  logic             r_ws;
  logic             r_frame_start;
  logic             r_underrun;
  logic             r_busy;
  logic             r_dsp;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;

  logic                  w_clear;
  logic                  w_load;
  logic                  w_adv;
  logic                  w_to_idle;
  logic                  w_bit_last;
  logic                  w_frame_last;
  logic [NUM_BITS_W-1:0] w_bit_idx;
  logic [NUM_WORD_W-1:0] w_word_idx;

  // Slot counter control: load marks the first bit of every new frame.
  always_comb begin
    w_clear   = 1'b0;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_to_idle = 1'b0;
    if (!cfg_en_i) begin
      w_clear   = 1'b1;
      w_to_idle = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_clear   = 1'b1;
          w_to_idle = !ready_to_send_i;
        end
        ARM: w_load = 1'b1;
        FRAME: begin
          if (w_frame_last) begin
            if (r_gap == '0) w_load  = 1'b1;
            else             w_clear = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_ONE) begin
            if (ready_to_send_i) begin
              w_load = 1'b1;
            end else begin
              w_clear   = 1'b1;
              w_to_idle = 1'b1;
            end
          end
        end
        default: begin
          w_clear   = 1'b1;
          w_to_idle = 1'b1;
        end
      endcase
    end
  end

  i2s_slot_counter #(
    .NUM_BITS_W (NUM_BITS_W),
    .NUM_WORD_W (NUM_WORD_W)
  ) u_slot_counter (
    .clk_i        (sck_i),
    .rstn_i       (rstn_i),
    .clear_i      (w_clear),
    .load_i       (w_load),
    .adv_i        (w_adv),
    .num_bits_i   (cfg_num_bits_i),
    .num_word_i   (cfg_num_word_i),
    .bit_idx_o    (w_bit_idx),
    .word_idx_o   (w_word_idx),
    .bit_last_o   (w_bit_last),
    .frame_last_o (w_frame_last)
  );

  // Frame FSM with registered WS, start, underrun and busy outputs.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= IDLE;
      r_ws          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_busy        <= 1'b0;
      r_dsp         <= 1'b0;
      r_gap         <= '0;
      r_gap_cnt     <= '0;
    end else if (!cfg_en_i) begin
      r_state       <= IDLE;
      r_ws          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_busy        <= 1'b0;
      r_gap_cnt     <= '0;
    end else begin
      r_frame_start <= w_load;
      // Underrun reflects the FIFO as seen during the frame-start cycle.
      r_underrun    <= r_frame_start & ~fifo_valid_i;
      case (r_state)
        IDLE: begin
          r_ws <= 1'b0;
          if (ready_to_send_i) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ARM: begin
          r_state <= FRAME;
          r_busy  <= 1'b1;
        end
        FRAME: begin
          if (w_frame_last) begin
            if (r_gap != '0) begin
              r_state   <= GAP;
              r_gap_cnt <= r_gap;
              r_ws      <= 1'b0;
            end
          end else if (r_dsp) begin
            r_ws <= 1'b0;
          end else begin
            // I2S level WS follows the word index parity of the next cycle.
            r_ws <= w_bit_last ? ~w_word_idx[0] : w_word_idx[0];
          end
        end
        GAP: begin
          r_ws <= 1'b0;
          if (r_gap_cnt == GAP_ONE) begin
            r_gap_cnt <= '0;
            if (ready_to_send_i) begin
              r_state <= FRAME;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // Every frame start relatches mode and gap; word 0 bit 0 sets WS in DSP mode only.
      if (w_load) begin
        r_dsp <= cfg_dsp_mode_i;
        r_gap <= cfg_gap_i;
        r_ws  <= cfg_dsp_mode_i;
      end
    end
  end

`ifdef I2S_TX_FRAME_CTRL_STATS_EN
  logic [I2S_FRAME_CNT_W-1:0] r_frame_cnt;

  // Completed-frame counter; wraps naturally and clears whenever the FSM idles.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_frame_cnt <= '0;
    end else if (w_to_idle) begin
      r_frame_cnt <= '0;
    end else if (w_frame_last && (r_state == FRAME)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`else
  assign frame_cnt_o = '0;
`endif

  assign ws_o          = r_ws;
  assign frame_start_o = r_frame_start;
  assign frame_done_o  = w_frame_last;
  assign word_idx_o    = w_word_idx;
  assign bit_idx_o     = w_bit_idx;
  assign busy_o        = r_busy;
  assign underrun_o    = r_underrun;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_i2s_tx_frame_ctrl.sv
// Directed bench for i2s_tx_frame_ctrl: a per-cycle vector table for a tiny
// frame, then hand-written multi-frame sequences checked against a frame model.
module tb_i2s_tx_frame_ctrl;
  import i2s_pkg::*;

`ifdef I2S_TX_FRAME_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic sck = 1'b0;
  logic rstn;
  always #5 sck = ~sck;

  logic        cfg_en, cfg_dsp, ready, fifo_valid;
  logic [4:0]  cfg_bits;
  logic [3:0]  cfg_words;
  logic [7:0]  cfg_gap;
  logic        ws, fstart, fdone, busy, under;
  logic [3:0]  word_idx;
  logic [4:0]  bit_idx;
  logic [15:0] frame_cnt;
  i2s_frame_state_e dbg_state;

  i2s_tx_frame_ctrl dut (
    .sck_i           (sck),
    .rstn_i          (rstn),
    .cfg_en_i        (cfg_en),
    .cfg_dsp_mode_i  (cfg_dsp),
    .cfg_num_bits_i  (cfg_bits),
    .cfg_num_word_i  (cfg_words),
    .cfg_gap_i       (cfg_gap),
    .ready_to_send_i (ready),
    .fifo_valid_i    (fifo_valid),
    .ws_o            (ws),
    .frame_start_o   (fstart),
    .frame_done_o    (fdone),
    .word_idx_o      (word_idx),
    .bit_idx_o       (bit_idx),
    .busy_o          (busy),
    .underrun_o      (under),
    .frame_cnt_o     (frame_cnt),
    .dbg_state_o     (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- helpers / scoreboard ----------------
  function automatic logic [13:0] mk(logic w, logic st, logic dn, logic [3:0] wi,
                                     logic [4:0] bi, logic bz, logic un);
    return {w, st, dn, wi, bi, bz, un};
  endfunction

  // Frame model: position p within a period of (nb+1)*(nw+1) bits plus gap.
  function automatic logic [13:0] exp_frame(int p, int nb, int nw, bit dsp, bit und);
    int flen;
    logic [3:0] w;
    logic [4:0] b;
    flen = (nb + 1) * (nw + 1);
    if (p < flen) begin
      b = 5'(p % (nb + 1));
      w = 4'(p / (nb + 1));
      return mk(dsp ? (p == 0) : w[0], p == 0, p == flen - 1, w, b, 1'b1, und);
    end
    return mk(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1, und);
  endfunction

  task automatic step();
    @(posedge sck);
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {ws, fstart, fdone, word_idx, bit_idx, busy, under};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {ws,st,dn,word,bit,busy,und}=%b_%b_%b_%h_%h_%b_%b want %b_%b_%b_%h_%h_%b_%b",
               name, act[13], act[12], act[11], act[10:7], act[6:2], act[1], act[0],
               exp[13], exp[12], exp[11], exp[10:7], exp[6:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (frame_cnt !== exp) begin
      failures++;
      $display("FAIL %s: frame_cnt got %0d want %0d", name, frame_cnt, exp);
    end
  endtask

  // Drop enable for a cycle, load config, enable, and step through ARM to t=0.
  task automatic start_seq(input string name, input int nb, input int nw,
                           input int gap, input bit dsp);
    cfg_en = 1'b0;
    step();
    check({name, " idle"}, mk(0, 0, 0, 4'd0, 5'd0, 0, 0));
    check_cnt({name, " idle cnt"}, 16'd0);
    cfg_bits   = 5'(nb);
    cfg_words  = 4'(nw);
    cfg_gap    = 8'(gap);
    cfg_dsp    = dsp;
    cfg_en     = 1'b1;
    ready      = 1'b1;
    fifo_valid = 1'b1;
    step();
    check({name, " arm"}, mk(0, 0, 0, 4'd0, 5'd0, 1, 0));
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic en, rdy, fifo;
    logic ws, st, dn;
    logic [3:0] word;
    logic [4:0] bidx;
    logic busy, und;
    i2s_frame_state_e state;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 2-bit words, 2 words, gap 2, I2S mode: period 6.
    vecs[0]  = '{0,0,1, 0,0,0, 4'd0,5'd0, 0,0, IDLE};
    vecs[1]  = '{1,1,1, 0,0,0, 4'd0,5'd0, 1,0, ARM};
    vecs[2]  = '{1,1,1, 0,1,0, 4'd0,5'd0, 1,0, FRAME};
    vecs[3]  = '{1,1,0, 0,0,0, 4'd0,5'd1, 1,1, FRAME};
    vecs[4]  = '{1,1,1, 1,0,0, 4'd1,5'd0, 1,0, FRAME};
    vecs[5]  = '{1,1,1, 1,0,1, 4'd1,5'd1, 1,0, FRAME};
    vecs[6]  = '{1,1,1, 0,0,0, 4'd0,5'd0, 1,0, GAP};
    vecs[7]  = '{1,1,1, 0,0,0, 4'd0,5'd0, 1,0, GAP};
    vecs[8]  = '{1,1,1, 0,1,0, 4'd0,5'd0, 1,0, FRAME};
    vecs[9]  = '{1,1,1, 0,0,0, 4'd0,5'd1, 1,0, FRAME};
    vecs[10] = '{1,0,1, 1,0,0, 4'd1,5'd0, 1,0, FRAME};
    vecs[11] = '{1,0,1, 1,0,1, 4'd1,5'd1, 1,0, FRAME};
    vecs[12] = '{1,0,1, 0,0,0, 4'd0,5'd0, 1,0, GAP};
    vecs[13] = '{1,0,1, 0,0,0, 4'd0,5'd0, 1,0, GAP};
    vecs[14] = '{1,0,1, 0,0,0, 4'd0,5'd0, 0,0, IDLE};

    // Reset
    rstn = 1'b0; cfg_en = 1'b0; cfg_dsp = 1'b0; ready = 1'b0; fifo_valid = 1'b1;
    cfg_bits = 5'd1; cfg_words = 4'd1; cfg_gap = 8'd2;
    step(); step();
    check("reset", mk(0, 0, 0, 4'd0, 5'd0, 0, 0));
    check_cnt("reset cnt", 16'd0);
    rstn = 1'b1;
    step();

    // Table-driven pass
    for (int i = 0; i < 15; i++) begin
      cfg_en = vecs[i].en; ready = vecs[i].rdy; fifo_valid = vecs[i].fifo;
      step();
      check($sformatf("vec%0d", i), mk(vecs[i].ws, vecs[i].st, vecs[i].dn, vecs[i].word,
                                        vecs[i].bidx, vecs[i].busy, vecs[i].und));
      checks++;
      if (dbg_state !== vecs[i].state) begin
        failures++;
        $display("FAIL vec%0d state: got %0d want %0d", i, dbg_state, vecs[i].state);
      end
    end

    // A: 16-bit x 2, gap 0, DSP: back-to-back frames every 32 cycles
    start_seq("A", 15, 1, 0, 1'b1);
    for (int t = 0; t < 96; t++) begin
      check($sformatf("A t=%0d", t), exp_frame(t % 32, 15, 1, 1'b1, 1'b0));
      step();
    end
    check_cnt("A frame_cnt after 3 frames", STATS ? 16'd3 : 16'd0);

    // B: 8-bit x 4, I2S, gap 4: period 36; FIFO empty at second frame start
    start_seq("B", 7, 3, 4, 1'b0);
    for (int t = 0; t < 72; t++) begin
      check($sformatf("B t=%0d", t), exp_frame(t % 36, 7, 3, 1'b0, t == 37));
      fifo_valid = (t == 36) ? 1'b0 : 1'b1;
      step();
    end
    check_cnt("B frame_cnt after 2 frames", STATS ? 16'd2 : 16'd0);

    // D: enable dropped mid word 1, then restart after 2-cycle latency
    start_seq("D", 15, 1, 0, 1'b1);
    for (int t = 0; t <= 20; t++) begin
      check($sformatf("D t=%0d", t), exp_frame(t, 15, 1, 1'b1, 1'b0));
      if (t < 20) step();
    end
    cfg_en = 1'b0;
    step();
    check("D en drop", mk(0, 0, 0, 4'd0, 5'd0, 0, 0));
    check_cnt("D en drop cnt", 16'd0);
    cfg_en = 1'b1;
    step();
    check("D re-arm", mk(0, 0, 0, 4'd0, 5'd0, 1, 0));
    step();

    // E: num_bits 15 -> 7 mid-frame; takes effect at the next frame
    for (int t = 0; t < 48; t++) begin
      if (t < 32) check($sformatf("E t=%0d", t), exp_frame(t, 15, 1, 1'b1, 1'b0));
      else        check($sformatf("E t=%0d", t), exp_frame(t - 32, 7, 1, 1'b1, 1'b0));
      if (t == 5) cfg_bits = 5'd7;
      step();
    end

    // F: 1-bit words (word index advances every cycle), 4 words, I2S
    start_seq("F", 0, 3, 0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      check($sformatf("F t=%0d", t), exp_frame(t % 4, 0, 3, 1'b0, 1'b0));
      step();
    end

    // G: single-slot frame in I2S mode: WS never rises; gap 1 -> period 5
    start_seq("G", 3, 0, 1, 1'b0);
    for (int t = 0; t < 12; t++) begin
      check($sformatf("G t=%0d", t), exp_frame(t % 5, 3, 0, 1'b0, 1'b0));
      if (t < 11) step();
    end

    // Asynchronous reset mid-frame
    #2;
    rstn = 1'b0;
    #1;
    check("async reset", mk(0, 0, 0, 4'd0, 5'd0, 0, 0));
    check_cnt("async reset cnt", 16'd0);
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL async reset state: got %0d want %0d", dbg_state, IDLE);
    end
    #1;
    rstn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
